alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD, SUB, AND, ORR, EOR, LSL, LSR) finish on the accept
// edge; MUL runs an iterative shift-add, one multiplier bit per cycle.
// Result and flags are held in DONE until the consumer takes them.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-low reset
//   SrcA, SrcB  operands (WIDTH bits)
//   ALUControl  operation select
//   in_valid    operation presented
//   in_ready    block can accept (IDLE only)
//   ALUResult   registered result
//   ALUFlag     registered flags {N,Z,C,V}
//   out_valid   ALUResult/ALUFlag valid
//   out_ready   consumer takes the result
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlag,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] result_next;
    logic [3:0]       flag_next;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH:0]   ext_l;
    logic [WIDTH:0]   ext_r;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc_step;

    // Single-cycle datapath; flags C/V computed per op
    always_comb begin : alu_comb
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        shamt   = SrcB[SHW-1:0];
        sum_add = {1'b0, SrcA} + {1'b0, SrcB};
        sum_sub = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH+1)'(1);
        // One spare bit on the far side catches the last bit shifted out;
        // a zero shift leaves the spare bit at 0, so C=0.
        ext_l   = {1'b0, SrcA} << shamt;
        ext_r   = {SrcA, 1'b0} >> shamt;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND: alu_res = SrcA & SrcB;
            OP_ORR: alu_res = SrcA | SrcB;
            OP_EOR: alu_res = SrcA ^ SrcB;
            OP_LSL: begin
                alu_res = ext_l[WIDTH-1:0];
                alu_c   = ext_l[WIDTH];
            end
            OP_LSR: begin
                alu_res = ext_r[WIDTH:1];
                alu_c   = ext_r[0];
            end
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath next values
    always_comb begin : fsm_comb
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        cnt_next    = cnt;
        result_next = ALUResult;
        flag_next   = ALUFlag;
        acc_step    = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_next  = SrcA;
                        mplier_next = SrcB;
                        acc_next    = '0;
                        cnt_next    = '0;
                        state_next  = MUL;
                    end else begin
                        result_next = alu_res;
                        flag_next   = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                        state_next  = DONE;
                    end
                end
            end
            MUL: begin
                // Multiplicand moves left as multiplier bits are consumed LSB first
                acc_next    = acc_step;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    result_next = acc_step;
                    flag_next   = {acc_step[WIDTH-1], acc_step == '0, 2'b00};
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            ALUResult <= '0;
            ALUFlag   <= 4'b0000;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            mcand     <= mcand_next;
            mplier    <= mplier_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            ALUResult <= result_next;
            ALUFlag   <= flag_next;
            out_valid <= (state_next == DONE);
            in_ready  <= (state_next == IDLE);
        end
    end

endmodule
